// File: rtl/noc_route_demux.sv
// Input FIFO feeding two registered output ports: local eject (out0) and forward (out1).
// Head-of-line routing on the destination field, with saturating per-port delivery counters.
module noc_route_demux #(
    parameter int          WIDTH_packet = 57,
    parameter logic [3:0]  LOCAL_ID     = 4'd0,
    parameter int          DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH_packet-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH_packet-1:0] out0_data,
    output logic                    out0_valid,
    input  logic                    out0_ready,
    output logic [WIDTH_packet-1:0] out1_data,
    output logic                    out1_valid,
    input  logic                    out1_ready,
    input  logic                    cnt_clr,
    output logic [15:0]             cnt0,
    output logic [15:0]             cnt1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH_packet-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic                    push;
    logic                    pop;
    logic                    head_valid;
    logic                    head_local;
    logic [WIDTH_packet-1:0] head;
    logic                    xfer0;
    logic                    xfer1;
    logic                    free0;
    logic                    free1;

    assign in_ready   = (count != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign head_local = (head[WIDTH_packet-1 -: 4] == LOCAL_ID);

    assign xfer0 = out0_valid && out0_ready;
    assign xfer1 = out1_valid && out1_ready;
    assign free0 = !out0_valid || out0_ready;
    assign free1 = !out1_valid || out1_ready;

    // Strict in-order: a head waiting on a busy port blocks everything behind it.
    assign pop = head_valid && (head_local ? free0 : free1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
        end else if (pop && head_local) begin
            out0_valid <= 1'b1;
            out0_data  <= head;
        end else if (xfer0) begin
            out0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
        end else if (pop && !head_local) begin
            out1_valid <= 1'b1;
            out1_data  <= head;
        end else if (xfer1) begin
            out1_valid <= 1'b0;
        end
    end

    // Clear wins over a same-edge delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (xfer0 && (cnt0 != 16'hFFFF)) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (xfer1 && (cnt1 != 16'hFFFF)) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_route_demux.sv
// Scoreboard bench for noc_route_demux: expected packets are queued per output
// port on acceptance and checked in order as each output handshake happens.
module tb_noc_route_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic [56:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [56:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic        cnt_clr;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;
    logic bulk = 1'b0;
    logic [56:0] q0[$];
    logic [56:0] q1[$];
    logic [56:0] e0;
    logic [56:0] e1;

    noc_route_demux #(
        .WIDTH_packet(57),
        .LOCAL_ID(4'd0),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out0_data(out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data(out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .cnt_clr(cnt_clr),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [56:0] mk(input logic [3:0] d, input logic [3:0] s,
                                       input logic [48:0] p);
        return {d, s, p};
    endfunction

    // Output monitor: pops the expected packet on every handshake.
    always @(negedge clk) begin
        if (!reset && !bulk) begin
            if (out0_valid && out0_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL out0_extra got %h want nothing", out0_data);
                end else begin
                    e0 = q0.pop_front();
                    if (out0_data !== e0) begin
                        errors++;
                        $display("FAIL out0_data got %h want %h", out0_data, e0);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_extra got %h want nothing", out1_data);
                end else begin
                    e1 = q1.pop_front();
                    if (out1_data !== e1) begin
                        errors++;
                        $display("FAIL out1_data got %h want %h", out1_data, e1);
                    end
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [56:0] p);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = p;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (p[56:53] == 4'd0) q0.push_back(p);
                else q1.push_back(p);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 want 1 for %h", p);
        end
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out0_valid, out1_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got %b want 100", {in_ready, out0_valid, out1_valid});
        end
        checks++;
        if ({out0_data, out1_data, cnt0, cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want 0", out0_data, out1_data, cnt0, cnt1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [56:0] p;
        p = mk(4'd0, 4'd2, 49'h1);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(p);
        checks++;
        if (out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early got %b want 0", out0_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== p) begin
            errors++;
            $display("FAIL single_latency got %b/%h want 1/%h", out0_valid, out0_data, p);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL single_cnt got %0d/%0d want 1/0", cnt0, cnt1);
        end
    endtask

    task automatic test_back_to_back();
        clear_cnt();
        send(mk(4'd5, 4'd1, 49'h11));
        send(mk(4'd0, 4'd1, 49'h22));
        send(mk(4'd5, 4'd1, 49'h33));
        send(mk(4'd0, 4'd1, 49'h44));
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (cnt0 !== 16'd2 || cnt1 !== 16'd2 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL b2b_cnt got %0d/%0d q%0d/%0d want 2/2 q0/0",
                     cnt0, cnt1, q0.size(), q1.size());
        end
    endtask

    task automatic test_full();
        logic [56:0] first;
        clear_cnt();
        out1_ready = 1'b0;
        first = mk(4'd3, 4'd4, 49'h100);
        send(first);
        for (int i = 1; i < 5; i++) send(mk(4'd3, 4'd4, 49'h100 + 49'(i)));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = mk(4'd3, 4'd4, 49'h1FF);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out1_valid !== 1'b1 || out1_data !== first) begin
            errors++;
            $display("FAIL full_hold got %b/%b/%h want 0/1/%h",
                     in_ready, out1_valid, out1_data, first);
        end
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || cnt1 !== 16'd5 || q1.size() != 0) begin
            errors++;
            $display("FAIL full_drain got %b/%0d q%0d want 1/5 q0", in_ready, cnt1, q1.size());
        end
    endtask

    task automatic test_hol();
        bit early = 0;
        out1_ready = 1'b0;
        out0_ready = 1'b1;
        send(mk(4'd3, 4'd6, 49'h200));
        send(mk(4'd3, 4'd6, 49'h201));
        send(mk(4'd0, 4'd6, 49'h202));
        repeat (4) begin
            @(negedge clk);
            if (out0_valid) early = 1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL hol_block got out0_valid=1 want 0");
        end
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL hol_drain got q%0d/%0d v%b want q0/0 v0", q0.size(), q1.size(), out0_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(4'd0, 4'd7, 49'h300 + 49'(i)));
        @(posedge clk);
        #1;
        checks++;
        if (out0_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre got %b/%b want 1/1", out0_valid, in_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1} !== '0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_async got v%b%b d%h c%0d/%0d r%b want zeros r1",
                     out0_valid, out1_valid, out0_data, cnt0, cnt1, in_ready);
        end
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out0_valid || out1_valid) stale = 1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL rmid_stale got valid=1 want 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        int n = 0;
        bit done = 0;
        clear_cnt();
        bulk = 1'b1;
        out0_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = mk(4'd0, 4'd9, 49'h5A5);
        for (int i = 0; i < 70000 && !done; i++) begin
            @(negedge clk);
            if (in_ready) n++;
            if (n == 65534) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bulk = 1'b0;
        checks++;
        if (cnt0 !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preset got %h want fffe", cnt0);
        end
        for (int i = 0; i < 3; i++) send(mk(4'd0, 4'd9, 49'h400 + 49'(i)));
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (cnt0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h want ffff", cnt0);
        end
        out0_ready = 1'b0;
        send(mk(4'd0, 4'd9, 49'h4FF));
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        cnt_clr    = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++;
        if (cnt0 !== 16'd0 || q0.size() != 0) begin
            errors++;
            $display("FAIL sat_clr got %h q%0d want 0 q0", cnt0, q0.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        cnt_clr    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_hol();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
